ifetch: RTL and testbench

Instruction fetch stage of the venus pipeline: the producer side of the decode stage's `inst_i` / `stall_o` interface. Holds the program counter, issues word reads to a synchronous instruction memory, and presents one 32-bit instruction word (`{opecode[6:0], immf, rd[3:0], rs[3:0], imm[15:0]}`) per cycle to decode. Honours decode back-pressure through a one-entry skid buffer and takes branch redirects from execute, squashing wrong-path words.

---
 rtl/ifetch.sv | 110 +++++++++++
 tb/tb_ifetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage for the venus pipeline.
// Holds the word-addressed program counter, issues reads to a synchronous
// instruction ROM, and hands one instruction per cycle to decode. A one-entry
// skid buffer catches the word already in flight when decode stalls.
// Branch redirects from execute squash every word still in flight.
module ifetch #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              imem_en_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [31:0]       imem_data_i,
   output logic [31:0]       inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              valid_o
);

   // Fetch state: next address to issue, plus the read issued last cycle.
   // When req_v is set, imem_data_i carries the word for req_pc.
   logic [ADDR_W-1:0] pc_q;
   logic              req_v;
   logic [ADDR_W-1:0] req_pc;

   // One-entry skid buffer for the word that lands while decode is stalled.
   logic              skid_v;
   logic [31:0]       skid_inst;
   logic [ADDR_W-1:0] skid_pc;

   // A new read goes out only when nothing is holding the front end back.
   // Reset keeps the ROM quiet so nothing is requested from a stale PC.
   always_comb begin
      imem_en_o   = !rst && !stall_i && !redirect_i;
      imem_addr_o = pc_q;
   end

   // PC and in-flight request tracking: a redirect reloads the PC, a stall
   // freezes it, and otherwise the current PC is issued and advanced. The
   // increment wraps at 2^ADDR_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         req_v  <= 1'b0;
         req_pc <= '0;
      end else if (redirect_i) begin
         pc_q  <= redirect_pc_i;
         req_v <= 1'b0;
      end else if (stall_i) begin
         req_v <= 1'b0;
      end else begin
         pc_q   <= pc_q + ADDR_W'(1);
         req_v  <= 1'b1;
         req_pc <= pc_q;
      end
   end

   // Skid buffer: catch the returning word on a stall, drain it on the
   // first free cycle, and throw it away on a redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_v    <= 1'b0;
         skid_inst <= 32'h0;
         skid_pc   <= '0;
      end else if (redirect_i) begin
         skid_v <= 1'b0;
      end else if (stall_i) begin
         if (req_v) begin
            skid_v    <= 1'b1;
            skid_inst <= imem_data_i;
            skid_pc   <= req_pc;
         end
      end else begin
         skid_v <= 1'b0;
      end
   end

   // Output register towards decode: the skid word has priority over the
   // live ROM data because it is older. A redirect drops valid but keeps the
   // last word and PC visible, and a stall holds everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_o  <= 32'h0;
         pc_o    <= '0;
         valid_o <= 1'b0;
      end else if (redirect_i) begin
         valid_o <= 1'b0;
      end else if (!stall_i) begin
         if (skid_v) begin
            inst_o  <= skid_inst;
            pc_o    <= skid_pc;
            valid_o <= 1'b1;
         end else if (req_v) begin
            inst_o  <= imem_data_i;
            pc_o    <= req_pc;
            valid_o <= 1'b1;
         end else begin
            valid_o <= 1'b0;
         end
      end
   end

   // A stall cycle never issues, so a full skid buffer and a live ROM word
   // can never coexist; if they do, a word would be lost.
   skidNeverOverrun: assert property (@(posedge clk) disable iff (rst) !(req_v && skid_v));

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: randomised and directed stall / redirect /
// reset traffic against a stream-level reference model, with a scoreboard
// queue between the stimulus and the output monitor.
module tb_ifetch;

   localparam int          AW       = 16;
   localparam logic [15:0] START_PC = 16'hFFFE;

   logic          clk;
   logic          rst;
   logic          stall_i;
   logic          redirect_i;
   logic [AW-1:0] redirect_pc_i;
   logic          imem_en_o;
   logic [AW-1:0] imem_addr_o;
   logic [31:0]   imem_data_i;
   logic [31:0]   inst_o;
   logic [AW-1:0] pc_o;
   logic          valid_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic          valid;
      logic [AW-1:0] pc;
      logic [31:0]   inst;
      logic          en;
      logic [AW-1:0] addr;
   } exp_t;

   typedef struct {
      logic [AW-1:0] pc;
      int            cyc;
   } issue_t;

   exp_t   expQ[$];
   issue_t inFlight[$];
   logic [AW-1:0] mNext  = START_PC;
   logic          mValid = 1'b0;
   logic [AW-1:0] mPc    = '0;
   logic [31:0]   mInst  = 32'h0;
   int            mCycle = 0;

   ifetch #(.ADDR_W(AW), .RESET_PC(START_PC)) dut (
      .clk(clk),
      .rst(rst),
      .stall_i(stall_i),
      .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .imem_en_o(imem_en_o),
      .imem_addr_o(imem_addr_o),
      .imem_data_i(imem_data_i),
      .inst_o(inst_o),
      .pc_o(pc_o),
      .valid_o(valid_o)
   );

   function automatic logic [31:0] memWord(input logic [AW-1:0] a);
      return 32'hA000_0000 + {16'h0, a};
   endfunction

   // Synchronous ROM; returns garbage when not enabled so stale reads show up.
   always @(posedge clk) begin
      imem_data_i <= imem_en_o ? memWord(imem_addr_o) : 32'hDEAD_BEEF;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
      end
   endtask

   // Reference model: words are fetched in address order from the last
   // restart point; a word issued in one cycle may reach decode at the end
   // of any later non-stalled cycle, one word per cycle.
   task automatic modelStep(input logic s, input logic r, input logic [AW-1:0] tgt, input logic rs);
      exp_t e;
      issue_t it;
      if (rs) begin
         inFlight.delete();
         mNext  = START_PC;
         mValid = 1'b0;
         mPc    = '0;
         mInst  = 32'h0;
      end else if (r) begin
         inFlight.delete();
         mNext  = tgt;
         mValid = 1'b0;
      end else if (!s) begin
         if (inFlight.size() > 0 && inFlight[0].cyc < mCycle) begin
            it     = inFlight.pop_front();
            mValid = 1'b1;
            mPc    = it.pc;
            mInst  = memWord(it.pc);
         end else begin
            mValid = 1'b0;
         end
         it.pc  = mNext;
         it.cyc = mCycle;
         inFlight.push_back(it);
         mNext = mNext + 16'd1;
      end
      mCycle++;
      e.valid = mValid;
      e.pc    = mPc;
      e.inst  = mInst;
      e.en    = !rs && !s && !r;
      e.addr  = mNext;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic s, input logic r, input logic [AW-1:0] tgt, input logic rs);
      @(negedge clk);
      stall_i       = s;
      redirect_i    = r;
      redirect_pc_i = tgt;
      rst           = rs;
      modelStep(s, r, tgt, rs);
      if (rs) begin
         #1;
         checkOutput("asyncRstValid", {31'h0, valid_o}, 32'h0);
         checkOutput("asyncRstPc", {16'h0, pc_o}, 32'h0);
         checkOutput("asyncRstInst", inst_o, 32'h0);
      end
   endtask

   // Monitor: one expected entry per clock edge, compared just after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("valid_o", {31'h0, valid_o}, {31'h0, e.valid});
            if (e.valid || !valid_o) begin
               checkOutput("pc_o", {16'h0, pc_o}, {16'h0, e.pc});
               checkOutput("inst_o", inst_o, e.inst);
            end
            checkOutput("imem_en_o", {31'h0, imem_en_o}, {31'h0, e.en});
            checkOutput("imem_addr_o", {16'h0, imem_addr_o}, {16'h0, e.addr});
         end
      end
   end

   initial begin
      rst           = 1'b1;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);

      // Cold start and free run across the address wrap.
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

      // Three-cycle stall mid-stream.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

      // Redirect while streaming.
      applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

      // Fill the skid, then redirect and stall together.
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

      // Alternating single-cycle stalls, then reset pulsed mid-stall.
      for (int i = 0; i < 20; i++) applyStimulus((i % 2) == 0, 1'b0, 16'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic rs, rd, st;
         rs = ($urandom_range(0, 99) < 2);
         rd = ($urandom_range(0, 99) < 6);
         st = ($urandom_range(0, 99) < 35);
         applyStimulus(st, rd, 16'($urandom_range(0, 65535)), rs);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

      @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
